// File: rtl/fpnew_shared_sched_pkg.sv
// Shared helpers for the multi-requester FPU scheduler.
// Only the index-width rule lives here.
package fpnew_shared_sched_pkg;

  function automatic int unsigned sched_idx_width(
    input int unsigned num_req
  );
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fpnew_shared_sched_arb.sv
// Round-robin pick: lowest eligible index at or after the pointer,
// otherwise lowest eligible index overall.
module fpnew_shared_sched_arb
  import fpnew_shared_sched_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [NumReq-1:0]   elig_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic                any_o,
  output logic [IdxWidth-1:0] idx_o
);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!any_o && elig_i[i] &&
          (IdxWidth'(i) >= ptr_i)) begin
        any_o = 1'b1;
        idx_o = IdxWidth'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!any_o && elig_i[i]) begin
        any_o = 1'b1;
        idx_o = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/fpnew_shared_sched.sv
// Shares one FPU among NumReq requesters: credit-limited RR issue,
// index-tagged responses steered back through a one-entry register.
module fpnew_shared_sched
  import fpnew_shared_sched_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqDataWidth   = 256,
  parameter int unsigned RspDataWidth   = 69,
  parameter int unsigned UserTagWidth   = 4,
  localparam int unsigned IdxWidth = sched_idx_width(NumReq),
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1),
  localparam int unsigned FTagW    = IdxWidth + UserTagWidth
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic [NumReq-1:0]                         req_valid_i,
  output logic [NumReq-1:0]                         req_ready_o,
  input  logic [NumReq-1:0][ReqDataWidth-1:0]       req_data_i,
  input  logic [NumReq-1:0][UserTagWidth-1:0]       req_tag_i,
  output logic                                      fpu_valid_o,
  input  logic                                      fpu_ready_i,
  output logic [ReqDataWidth-1:0]                   fpu_data_o,
  output logic [FTagW-1:0]                          fpu_tag_o,
  input  logic                                      fpu_valid_i,
  output logic                                      fpu_ready_o,
  input  logic [RspDataWidth-1:0]                   fpu_data_i,
  input  logic [FTagW-1:0]                          fpu_tag_i,
  output logic [NumReq-1:0]                         rsp_valid_o,
  input  logic [NumReq-1:0]                         rsp_ready_i,
  output logic [RspDataWidth-1:0]                   rsp_data_o,
  output logic [UserTagWidth-1:0]                   rsp_tag_o,
  output logic                                      busy_o
);

  typedef enum logic {Idle, Hold} lock_e;

  typedef struct packed {
    logic [IdxWidth-1:0]     idx;
    logic [UserTagWidth-1:0] tag;
    logic [RspDataWidth-1:0] data;
  } rsp_entry_t;

  lock_e                             state_q, state_d;
  logic [IdxWidth-1:0]               hold_idx_q, hold_idx_d;
  logic [IdxWidth-1:0]               ptr_q, ptr_d;
  logic [NumReq-1:0][CntWidth-1:0]   cnt_q, cnt_d;
  logic                              full_q, full_d;
  rsp_entry_t                        ent_q, ent_d;

  logic [NumReq-1:0]   elig;
  logic [IdxWidth-1:0] arb_idx, sel, in_idx;
  logic                arb_any, issue, rsp_hs, load, idx_ok;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] &&
        (cnt_q[i] < CntWidth'(MaxOutstanding));
    end
  end

  fpnew_shared_sched_arb #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) i_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .any_o  (arb_any),
    .idx_o  (arb_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      hold_idx_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      ent_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_idx_q <= hold_idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      ent_q      <= ent_d;
    end
  end

  // Once an offer is stalled, the selection is frozen until taken.
  always_comb begin
    state_d    = state_q;
    hold_idx_d = hold_idx_q;
    unique case (state_q)
      Idle: begin
        if (fpu_valid_o && !fpu_ready_i) begin
          state_d    = Hold;
          hold_idx_d = arb_idx;
        end
      end
      Hold: begin
        if (fpu_ready_i || flush_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    sel         = (state_q == Hold) ? hold_idx_q : arb_idx;
    fpu_valid_o = rst_ni && !flush_i &&
      ((state_q == Hold) ? elig[sel] : arb_any);
    issue       = fpu_valid_o && fpu_ready_i;
    req_ready_o = '0;
    if (issue) req_ready_o[sel] = 1'b1;
    fpu_data_o  = req_data_i[sel];
    fpu_tag_o   = {sel, req_tag_i[sel]};
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (sel == IdxWidth'(NumReq - 1)) ?
        '0 : sel + 1'b1;
    end
  end

  always_comb begin
    in_idx = fpu_tag_i[UserTagWidth +: IdxWidth];
    idx_ok = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (in_idx == IdxWidth'(i)) idx_ok = 1'b1;
    end
    rsp_hs      = full_q && rsp_ready_i[ent_q.idx];
    fpu_ready_o = rst_ni &&
      (!full_q || rsp_ready_i[ent_q.idx]);
    load        = fpu_valid_i && fpu_ready_o && idx_ok;
  end

  // Draining and refilling in one cycle keeps the slot full.
  always_comb begin
    full_d = full_q;
    ent_d  = ent_q;
    if (rsp_hs) full_d = 1'b0;
    if (load) begin
      full_d    = 1'b1;
      ent_d.idx  = in_idx;
      ent_d.tag  = fpu_tag_i[UserTagWidth-1:0];
      ent_d.data = fpu_data_i;
    end
    if (flush_i) full_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i]
        + CntWidth'(issue && (sel == IdxWidth'(i)))
        - CntWidth'(rsp_hs && (ent_q.idx == IdxWidth'(i)));
      if (flush_i) cnt_d[i] = '0;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = rst_ni && full_q &&
        (ent_q.idx == IdxWidth'(i));
    end
    rsp_data_o = ent_q.data;
    rsp_tag_o  = ent_q.tag;
    busy_o     = full_q || (|cnt_q);
  end

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (rsp_hs && !flush_i) |-> (cnt_q[ent_q.idx] != '0));

  a_tag_in_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (fpu_valid_i && fpu_ready_o) |-> idx_ok);

endmodule

// File: tb/tb_fpnew_shared_sched.sv
// Random traffic against a transaction-level model of the scheduler.
// Requesters and a stub FPU live in the bench.
module tb_fpnew_shared_sched;
  import fpnew_shared_sched_pkg::*;

  localparam int N   = 4;
  localparam int MO  = 4;
  localparam int RQW = 256;
  localparam int RSW = 69;
  localparam int UTW = 4;
  localparam int IW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_ni, flush_i;
  logic [N-1:0]            req_valid_i, req_ready_o;
  logic [N-1:0][RQW-1:0]   req_data_i;
  logic [N-1:0][UTW-1:0]   req_tag_i;
  logic                    fpu_valid_o, fpu_ready_i;
  logic [RQW-1:0]          fpu_data_o;
  logic [IW+UTW-1:0]       fpu_tag_o;
  logic                    fpu_valid_i, fpu_ready_o;
  logic [RSW-1:0]          fpu_data_i;
  logic [IW+UTW-1:0]       fpu_tag_i;
  logic [N-1:0]            rsp_valid_o, rsp_ready_i;
  logic [RSW-1:0]          rsp_data_o;
  logic [UTW-1:0]          rsp_tag_o;
  logic                    busy_o;

  fpnew_shared_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_tag_i   (req_tag_i),
    .fpu_valid_o (fpu_valid_o),
    .fpu_ready_i (fpu_ready_i),
    .fpu_data_o  (fpu_data_o),
    .fpu_tag_o   (fpu_tag_o),
    .fpu_valid_i (fpu_valid_i),
    .fpu_ready_o (fpu_ready_o),
    .fpu_data_i  (fpu_data_i),
    .fpu_tag_i   (fpu_tag_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tag_o   (rsp_tag_o),
    .busy_o      (busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tg,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    end
  endtask

  typedef struct {
    int             idx;
    logic [UTW-1:0] tag;
    logic [RSW-1:0] d;
  } op_t;

  // reference model state
  int             cnt [N];
  int             ptr, held;
  bit             hold, m_full;
  int             m_idx;
  logic [UTW-1:0] m_tag;
  logic [RSW-1:0] m_dat;

  // requesters and stub FPU
  bit             pend [N];
  logic [RQW-1:0] pdat [N];
  logic [UTW-1:0] ptag [N];
  op_t            infl [$];
  bit             fpres;
  op_t            fop;

  int p_req [7] = '{80, 100, 60, 100, 70, 70, 100};
  int p_fr  [7] = '{100, 70, 50, 90, 60, 60, 0};
  int p_out [7] = '{100, 70, 10, 60, 50, 50, 0};
  int p_rr  [7] = '{100, 60, 90, 30, 50, 60, 100};

  function automatic bit roll(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0;
    req_valid_i = '0; req_data_i = '0; req_tag_i = '0;
    fpu_ready_i = 1'b0; fpu_valid_i = 1'b0;
    fpu_data_i = '0; fpu_tag_i = '0; rsp_ready_i = '0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; pend[i] = 0; pdat[i] = '0; ptag[i] = '0;
    end
    ptr = 0; held = 0; hold = 0; m_full = 0; m_idx = 0;
    m_tag = '0; m_dat = '0; fpres = 0;

    for (int c = 0; c < 3010; c++) begin
      int           ph, sel;
      bit           ev, any, issue, rhs, load;
      logic [N-1:0] elig, e_rr, e_rv;
      bit           e_fro, e_busy;
      ph = (c >= 3000) ? 6 : c / 500;
      @(negedge clk);

      rst_ni  = !(c < 2 || c >= 3005 ||
                  (ph == 5 && $urandom_range(0, 199) == 0));
      flush_i = (ph == 4 || ph == 5) &&
                ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && roll(p_req[ph])) begin
          pend[i] = 1;
          pdat[i] = {8{$urandom()}};
          ptag[i] = UTW'($urandom());
        end
        req_valid_i[i] = pend[i];
        req_data_i[i]  = pdat[i];
        req_tag_i[i]   = ptag[i];
        rsp_ready_i[i] = roll(p_rr[ph]);
      end
      fpu_ready_i = roll(p_fr[ph]);
      if (!fpres && infl.size() > 0 && roll(p_out[ph])) begin
        int k;
        k = $urandom_range(0, infl.size() - 1);
        fop = infl[k];
        infl.delete(k);
        fpres = 1;
      end
      fpu_valid_i = fpres;
      fpu_tag_i   = {IW'(fop.idx), fop.tag};
      fpu_data_i  = fop.d;
      #1;

      // expected behaviour from current model state
      any = 0; sel = 0;
      for (int i = 0; i < N; i++)
        elig[i] = pend[i] && cnt[i] < MO;
      if (hold) begin
        sel = held; any = elig[held];
      end else begin
        for (int j = 0; j < N; j++) begin
          if (!any && elig[(ptr + j) % N]) begin
            any = 1; sel = (ptr + j) % N;
          end
        end
      end
      ev    = rst_ni && !flush_i && any;
      issue = ev && fpu_ready_i;
      e_rr  = '0;
      if (issue) e_rr[sel] = 1'b1;
      e_fro = rst_ni && (!m_full || rsp_ready_i[m_idx]);
      e_rv  = '0;
      if (rst_ni && m_full) e_rv[m_idx] = 1'b1;
      e_busy = m_full;
      for (int i = 0; i < N; i++)
        if (cnt[i] != 0) e_busy = 1;

      check("fpu_valid_o", 256'(fpu_valid_o), 256'(ev));
      check("req_ready_o", 256'(req_ready_o), 256'(e_rr));
      check("fpu_ready_o", 256'(fpu_ready_o), 256'(e_fro));
      check("rsp_valid_o", 256'(rsp_valid_o), 256'(e_rv));
      check("busy_o", 256'(busy_o), 256'(e_busy));
      if (ev) begin
        check("fpu_tag_o", 256'(fpu_tag_o),
              256'({IW'(sel), ptag[sel]}));
        check("fpu_data_o", fpu_data_o, pdat[sel]);
      end
      if (rst_ni && m_full) begin
        check("rsp_tag_o", 256'(rsp_tag_o), 256'(m_tag));
        check("rsp_data_o", 256'(rsp_data_o), 256'(m_dat));
      end

      // advance model to the state after the coming edge
      rhs  = m_full && rsp_ready_i[m_idx];
      load = fpu_valid_i && e_fro;
      if (!rst_ni) begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        ptr = 0; hold = 0; m_full = 0;
        infl.delete(); fpres = 0;
      end else if (flush_i) begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        hold = 0; m_full = 0;
        infl.delete(); fpres = 0;
      end else begin
        if (issue) begin
          op_t op;
          cnt[sel]++;
          ptr  = (sel + 1) % N;
          hold = 0;
          pend[sel] = 0;
          op.idx = sel;
          op.tag = ptag[sel];
          op.d   = ~pdat[sel][RSW-1:0];
          infl.push_back(op);
        end else if (ev) begin
          hold = 1; held = sel;
        end
        if (rhs) begin
          cnt[m_idx]--;
          m_full = 0;
        end
        if (load) begin
          m_full = 1; m_idx = fop.idx;
          m_tag = fop.tag; m_dat = fop.d;
          fpres = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
